uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Byte-oriented UART transmitter. Serialises one parallel byte per valid/ready handshake onto the `tx` line.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Sits on the FPGA side of the UART link. Its `tx` output feeds the line watched by the loopback/monitor block, so the board can originate traffic as well as echo it.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, truncated; 868 at the defaults.
- DATA_BITS, 8: data bits per frame. Legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- tx_data, input, 8: byte to send. Bits above DATA_BITS-1 are ignored.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: block can accept a byte.
- tx, output, 1: serial line output. Idle level is 1.
- tx_busy, output, 1: high while a frame is on the line.
- tx_done, output, 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset values (registered, one cycle after rst is sampled high): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame; the next edge returns tx to 1 with no partial stop bit.
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into a shift register on acceptance. Later changes to tx_data have no effect.
  - tx_ready is 1 only in IDLE. tx_valid while busy is ignored and does not queue.
- State machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. On acceptance go to START and clear the bit timer.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift out bit 0 first. Each bit is held exactly CLKS_PER_BIT cycles. Leave after DATA_BITS bits.
  - PARITY: present only if PARITY != 0. Bit = XOR of the data bits (even); inverted for odd.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx falls on the first edge after the acceptance edge. The line is never low before acceptance.
- tx_done pulses 1 for exactly one cycle, on the same edge that the state returns to IDLE (tx_ready rises together with it).
- tx_busy = (state != IDLE).
- Back-to-back frames with tx_valid held high: exactly one IDLE cycle (tx=1) separates the last stop cycle from the next start bit. Frame period = (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs at terminal count.
- The bit-index counter is clog2(DATA_BITS+1) wide and never wraps mid-frame.
- tx is driven from a flop only (no combinational path to the pin), so there are no glitches.
- Simultaneous rst and tx_valid: reset wins and the byte is not accepted.
- Elaboration check: CLKS_PER_BIT < 2 is a fatal error.

Decomposition:
- Shared header uart_defs.vh, also used by the receiver and the monitor:
  - state encodings (IDLE/START/DATA/PARITY/STOP);
  - PARITY_NONE/ODD/EVEN constants;
  - the CLKS_PER_BIT calculation macro.
- One sub-module, uart_baud_gen: parameterised divider with a synchronous clear and a single-cycle bit_tick output. The FSM clears it on acceptance, so the start bit is full width.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so 10 clocks/bit; 8N1 unless noted):
- After reset, send 0x55 -> tx=0 for cycles 1-10 after acceptance, then 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for 10 cycles. tx_done pulses at cycle 101; tx_ready=0 throughout the frame.
- 0xA3 with PARITY=2, STOP_BITS=2 -> data bits 1,1,0,0,0,1,0,1, parity bit 0, 20 stop cycles. tx_done at cycle 121.
- tx_valid held high with 0x00 then 0xFF -> second start bit falls exactly 1 cycle after the first frame's last stop cycle. No byte is dropped or duplicated.
- tx_valid pulsed with 0x12 during the data phase of an in-flight 0x34 frame -> 0x12 is never transmitted; the 0x34 frame is unaltered.
- rst asserted on cycle 45 of a frame -> tx=1, tx_ready=1, tx_busy=0 on the next edge, and no tx_done pulse. A new 0x0F sent afterwards is transmitted correctly.
- tx_data changed on the cycle after acceptance of 0xC3 -> the line still carries 0xC3.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART types and helpers.
// State encodings, parity modes and bit-period math.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

    // Parity over the low nbits of d; odd mode inverts the XOR.
    function automatic logic frame_parity(
        input logic [7:0] d,
        input int         nbits,
        input int         mode
    );
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                p = p ^ d[i];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_baud_gen: bit-period divider.
// Counts 0..CLKS_PER_BIT-1, ticks at terminal count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic i_clr,
    output logic o_bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term     = (r_cnt == TERM);
    assign o_bit_tick = w_term;

    // Free-running bit timer, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter.
// start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
        $fatal(1, "uart_tx: DATA_BITS must be 5..8");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD &&
        PARITY != PARITY_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [IW-1:0]   r_idx;
    logic            r_par;
    logic            r_tx;
    logic            r_done;

    state_t          w_state_nxt;
    logic [7:0]      w_shift_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_par_nxt;
    logic            w_tx_nxt;
    logic            w_done_nxt;
    logic            w_idle;
    logic            w_accept;
    logic            w_tick;
    logic            w_clr;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = tx_valid && w_idle;
    // Timer rests at zero in IDLE, so the start bit is full width.
    assign w_clr    = rst || w_idle;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .i_clr      (w_clr),
        .o_bit_tick (w_tick)
    );

    // Next-state, shift register, bit index and done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = tx_data;
                    w_idx_nxt   = '0;
                    w_par_nxt   = frame_parity(tx_data, DATA_BITS, PARITY);
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY
                                                              : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_idx == LAST_STOP) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Line level for the coming state, registered so the pin is glitch-free.
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_state_nxt)
            ST_IDLE:   w_tx_nxt = 1'b1;
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            ST_STOP:   w_tx_nxt = 1'b1;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tx_ready = w_idle;
    assign tx_busy  = !w_idle;
    assign tx       = r_tx;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// One 8N1 instance and one 8E2 instance at 10 clocks per bit.
module tb_uart_tx;

    localparam int CF  = 1_000_000;
    localparam int BD  = 100_000;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d1, d2;
    logic       v1, v2;
    logic       rdy1, tx1, busy1, done1;
    logic       rdy2, tx2, busy2, done2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ  (CF),
        .BAUD      (BD),
        .DATA_BITS (8),
        .PARITY    (0),
        .STOP_BITS (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (d1),
        .tx_valid (v1),
        .tx_ready (rdy1),
        .tx       (tx1),
        .tx_busy  (busy1),
        .tx_done  (done1)
    );

    uart_tx #(
        .CLK_FREQ  (CF),
        .BAUD      (BD),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (2)
    ) u_dut_e2 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (d2),
        .tx_valid (v2),
        .tx_ready (rdy2),
        .tx       (tx2),
        .tx_busy  (busy2),
        .tx_done  (done2)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected line level n cycles after the acceptance edge.
    function automatic logic exp_tx(
        input logic [7:0] d,
        input int         n,
        input int         par
    );
        int k;
        k = (n - 1) / CPB;
        if (n < 1) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (par != 0 && k == 9) return (par == 1) ? ~(^d) : ^d;
        return 1'b1;
    endfunction

    function automatic int par_of(input int which);
        return (which == 2) ? 2 : 0;
    endfunction

    function automatic int period(input int which);
        return (which == 2) ? (1 + 8 + 1 + 2) * CPB + 1
                            : (1 + 8 + 1) * CPB + 1;
    endfunction

    function automatic logic s_tx(input int which);
        return (which == 2) ? tx2 : tx1;
    endfunction
    function automatic logic s_rdy(input int which);
        return (which == 2) ? rdy2 : rdy1;
    endfunction
    function automatic logic s_busy(input int which);
        return (which == 2) ? busy2 : busy1;
    endfunction
    function automatic logic s_done(input int which);
        return (which == 2) ? done2 : done1;
    endfunction

    task automatic drive(
        input int         which,
        input logic       v,
        input logic [7:0] d
    );
        if (which == 2) begin
            v2 = v;
            d2 = d;
        end else begin
            v1 = v;
            d1 = d;
        end
    endtask

    // Called at a negedge; returns just after the acceptance edge.
    task automatic accept(input int which, input logic [7:0] d);
        int w;
        w = 0;
        drive(which, 1'b1, d);
        while (s_rdy(which) !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", (w < 300), 1);
        @(posedge clk);
    endtask

    // Watches ncyc cycles; nb = frames expected (0, 1 or 2 back-to-back).
    task automatic mon(
        input  int         which,
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  int         nb,
        input  int         ncyc,
        input  int         e1,
        input  logic       e1v,
        input  logic [7:0] e1d,
        input  int         e2,
        input  logic       e2v,
        input  logic [7:0] e2d,
        input  int         e3,
        input  logic       e3v,
        input  logic [7:0] e3d,
        output int         bad,
        output int         dcnt,
        output int         dfirst,
        output int         bcnt,
        output int         rbad
    );
        int   fl;
        logic e;
        fl     = period(which);
        bad    = 0;
        dcnt   = 0;
        dfirst = 0;
        bcnt   = 0;
        rbad   = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (nb >= 1 && n <= fl) e = exp_tx(a, n, par_of(which));
            else if (nb == 2 && n <= 2 * fl)
                e = exp_tx(b, n - fl, par_of(which));
            else e = 1'b1;
            if (s_tx(which) !== e) bad++;
            if (s_done(which) === 1'b1) begin
                dcnt++;
                if (dfirst == 0) dfirst = n;
            end
            if (s_busy(which) === 1'b1) bcnt++;
            if (nb >= 1 && n < fl && s_rdy(which) !== 1'b0) rbad++;
            if (n == e1) drive(which, e1v, e1d);
            if (n == e2) drive(which, e2v, e2d);
            if (n == e3) drive(which, e3v, e3d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, dc, df, bc, rb;

        rst = 1'b1;
        v1 = 1'b0;
        v2 = 1'b0;
        d1 = 8'h00;
        d2 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx1", tx1, 1);
        check("rst_rdy1", rdy1, 1);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_tx2", tx2, 1);
        check("rst_rdy2", rdy2, 1);
        check("rst_busy2", busy2, 0);
        check("rst_done2", done2, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0x55, 8N1
        accept(1, 8'h55);
        mon(1, 8'h55, 8'h00, 1, 110, 1, 1'b0, 8'h55, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("f55_line", bad, 0);
        check("f55_done_cycle", df, 101);
        check("f55_done_count", dc, 1);
        check("f55_busy_cycles", bc, 100);
        check("f55_ready_low", rb, 0);

        // 0xA3, 8E2
        accept(2, 8'hA3);
        mon(2, 8'hA3, 8'h00, 1, 130, 1, 1'b0, 8'hA3, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("fa3_line", bad, 0);
        check("fa3_done_cycle", df, 121);
        check("fa3_done_count", dc, 1);
        check("fa3_busy_cycles", bc, 120);
        check("fa3_ready_low", rb, 0);

        // Back-to-back 0x00 then 0xFF with valid held
        accept(1, 8'h00);
        mon(1, 8'h00, 8'hFF, 2, 230, 1, 1'b1, 8'hFF, 150, 1'b0, 8'hFF,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("b2b_line", bad, 0);
        check("b2b_done_count", dc, 2);
        check("b2b_first_done", df, 101);
        check("b2b_busy_cycles", bc, 200);

        // 0x12 offered mid-frame of 0x34 is dropped
        accept(1, 8'h34);
        mon(1, 8'h34, 8'h00, 1, 140, 1, 1'b0, 8'h34, 35, 1'b1, 8'h12,
            36, 1'b0, 8'h12, bad, dc, df, bc, rb);
        check("busy_ign_line", bad, 0);
        check("busy_ign_done", dc, 1);
        check("busy_ign_busy", bc, 100);

        // Data changes right after acceptance of 0xC3
        accept(1, 8'hC3);
        mon(1, 8'hC3, 8'h00, 1, 110, 1, 1'b0, 8'h3C, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("c3_line", bad, 0);
        check("c3_done_cycle", df, 101);

        // Reset in the middle of a frame
        accept(1, 8'h55);
        mon(1, 8'h55, 8'h00, 1, 44, 1, 1'b0, 8'h55, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("mid_pre_line", bad, 0);
        check("mid_busy", busy1, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tx", tx1, 1);
        check("mid_rst_rdy", rdy1, 1);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        rst = 1'b0;
        mon(1, 8'h00, 8'h00, 0, 30, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("post_rst_line", bad, 0);
        check("post_rst_done", dc, 0);
        check("post_rst_busy", bc, 0);
        accept(1, 8'h0F);
        mon(1, 8'h0F, 8'h00, 1, 110, 1, 1'b0, 8'h0F, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("f0f_line", bad, 0);
        check("f0f_done_cycle", df, 101);
        check("f0f_done_count", dc, 1);

        // Reset and valid together: byte not accepted
        drive(1, 1'b1, 8'hAA);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstv_rdy", rdy1, 1);
        check("rstv_busy", busy1, 0);
        check("rstv_tx", tx1, 1);
        rst = 1'b0;
        drive(1, 1'b0, 8'hAA);
        mon(1, 8'h00, 8'h00, 0, 20, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00,
            0, 1'b0, 8'h00, bad, dc, df, bc, rb);
        check("rstv_after_line", bad, 0);
        check("rstv_after_busy", bc, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
